// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path: default widths and the
// layout of a stored FIFO entry ({sof, byte}).
package spi_pkg;

    localparam int SPI_DATA_W     = 8;
    localparam int SPI_FIFO_DEPTH = 16;

    // Entry carries the payload plus one start-of-frame tag bit on top.
    function automatic int entry_width(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int sof_index(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit registered rising-edge detector; feed an inverted signal to
// detect falling edges.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/spi_rx_byte_fifo.sv
// Receive byte FIFO behind the SPI master: one push per byte_write rising
// edge, first byte of each chip-select frame tagged, registered pop.
module spi_rx_byte_fifo
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int DEPTH  = SPI_FIFO_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_write,
    input  logic [DATA_W-1:0] miso_byte,
    input  logic              cs_n,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_sof,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int              ENTRY_W  = entry_width(DATA_W);
    localparam int              SOF_BIT  = sof_index(DATA_W);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] rd_entry;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    cnt;
    logic               sof_arm;
    logic               wr_req;
    logic               cs_fall;
    logic               push;
    logic               pop;

    rise_detect u_bw_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (byte_write),
        .rise (wr_req)
    );

    // Register resets low, i.e. cs_n is assumed high coming out of reset.
    rise_detect u_cs_fall (
        .clk  (clk),
        .rst  (rst),
        .d    (~cs_n),
        .rise (cs_fall)
    );

    assign count    = cnt;
    assign empty    = (cnt == '0);
    assign full     = (cnt == FULL_CNT);
    assign pop      = rd_en & ~empty;
    // A full FIFO still accepts a byte when a pop frees a slot this cycle.
    assign push     = wr_req & (~full | pop);
    assign rd_entry = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sof_arm, miso_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            sof_arm   <= 1'b0;
            rd_data   <= '0;
            rd_sof    <= 1'b0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= rd_entry[DATA_W-1:0];
                rd_sof  <= rd_entry[SOF_BIT];
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
            rd_valid <= pop;

            // The push above already captured the old tag before re-arming.
            if (cs_fall) begin
                sof_arm <= 1'b1;
            end else if (push) begin
                sof_arm <= 1'b0;
            end

            if (wr_req && full && !pop) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_byte_fifo.sv
// Randomised and directed bench for spi_rx_byte_fifo with a queue-based
// reference model and a scoreboard monitor on the read port.
module tb_spi_rx_byte_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_write;
    logic [7:0] miso_byte;
    logic       cs_n;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rd_sof;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [8:0] m_q[$];
    logic [8:0] exp_q[$];
    logic       m_bw, m_cs, m_arm, m_ovf, m_unf, m_vld;
    logic [7:0] last_rd;
    logic       last_sof;

    spi_rx_byte_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .byte_write (byte_write),
        .miso_byte  (miso_byte),
        .cs_n       (cs_n),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_sof     (rd_sof),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural model of one clock edge, from the inputs applied to it.
    task automatic model_tick();
        logic wr, fall, do_pop, do_push, ovf_set, unf_set;
        if (rst) begin
            m_q.delete();
            m_bw = 1'b0; m_cs = 1'b1; m_arm = 1'b0;
            m_ovf = 1'b0; m_unf = 1'b0; m_vld = 1'b0;
            return;
        end
        wr      = byte_write && !m_bw;
        fall    = m_cs && !cs_n;
        do_pop  = rd_en && (m_q.size() != 0);
        do_push = wr && ((m_q.size() < 16) || do_pop);
        ovf_set = wr && (m_q.size() == 16) && !do_pop;
        unf_set = rd_en && (m_q.size() == 0);
        if (do_pop) exp_q.push_back(m_q.pop_front());
        if (do_push) m_q.push_back({m_arm, miso_byte});
        m_vld = do_pop;
        if (fall) m_arm = 1'b1;
        else if (do_push) m_arm = 1'b0;
        m_ovf = ovf_set ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
        m_unf = unf_set ? 1'b1 : (err_clr ? 1'b0 : m_unf);
        m_bw = byte_write;
        m_cs = cs_n;
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        chk("count", 32'(count), 32'(m_q.size()));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("full", 32'(full), 32'(m_q.size() == 16));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("rd_valid", 32'(rd_valid), 32'(m_vld));
    endtask

    task automatic push_byte(input logic [7:0] b, input int hi, input int lo);
        byte_write = 1'b1;
        miso_byte  = b;
        repeat (hi) step();
        byte_write = 1'b0;
        repeat (lo) step();
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        repeat (n) step();
        rd_en = 1'b0;
        step();
    endtask

    // Scoreboard monitor: every rd_valid must match the oldest expected pop.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rd_valid: got data %0h, required no read", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(e[7:0]));
                    chk("rd_sof", 32'(rd_sof), 32'(e[8]));
                    last_rd  = rd_data;
                    last_sof = rd_sof;
                end
            end
        end
    end

    initial begin
        rst = 1'b1; byte_write = 1'b0; miso_byte = 8'h00;
        cs_n = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("reset_rd_data", 32'(rd_data), 32'h0);
        chk("reset_empty", 32'(empty), 32'h1);
        rst = 1'b0;
        step();

        // Frame of three bytes, first tagged
        cs_n = 1'b0;
        step();
        push_byte(8'hA1, 50, 5);
        push_byte(8'hB2, 50, 5);
        push_byte(8'hC3, 50, 5);
        chk("count_three", 32'(count), 32'd3);
        pop_n(1);
        chk("first_byte_sof", 32'({last_sof, last_rd}), 32'h1A1);
        pop_n(2);
        chk("third_byte", 32'({last_sof, last_rd}), 32'h0C3);

        // Long byte_write high phase yields one push
        byte_write = 1'b1;
        repeat (200) begin
            miso_byte = 8'($urandom);
            step();
        end
        byte_write = 1'b0;
        step();
        chk("long_high_one_push", 32'(count), 32'd1);
        pop_n(1);

        // Overflow: 17 pushes, 16 kept
        for (int i = 0; i < 17; i++) push_byte(8'(i), 2, 1);
        chk("full_after_17", 32'(full), 32'h1);
        chk("overflow_after_17", 32'(overflow), 32'h1);
        pop_n(16);
        chk("last_of_16", 32'(last_rd), 32'h0F);
        chk("empty_after_16", 32'(empty), 32'h1);

        // Full with simultaneous push and pop
        err_clr = 1'b1; step(); err_clr = 1'b0; step();
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i), 2, 1);
        byte_write = 1'b1; miso_byte = 8'h5A; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        step();
        byte_write = 1'b0;
        step();
        chk("full_pushpop_count", 32'(count), 32'd16);
        chk("full_pushpop_ovf", 32'(overflow), 32'h0);
        pop_n(16);
        chk("full_pushpop_last", 32'(last_rd), 32'h5A);

        // Underflow and sticky clear priority
        rd_en = 1'b1; step(); rd_en = 1'b0; step();
        chk("underflow_set", 32'(underflow), 32'h1);
        err_clr = 1'b1; step(); err_clr = 1'b0; step();
        chk("underflow_clr", 32'(underflow), 32'h0);
        err_clr = 1'b1; rd_en = 1'b1; step(); err_clr = 1'b0; rd_en = 1'b0; step();
        chk("underflow_set_wins", 32'(underflow), 32'h1);
        err_clr = 1'b1; step(); err_clr = 1'b0; step();

        // Frame toggling between bytes, then reset mid-frame
        cs_n = 1'b1; step(); cs_n = 1'b0; step();
        push_byte(8'h11, 3, 2);
        cs_n = 1'b1; step(); cs_n = 1'b0; step();
        push_byte(8'h22, 3, 2);
        pop_n(1);
        chk("frame_a_sof", 32'({last_sof, last_rd}), 32'h111);
        pop_n(1);
        chk("frame_b_sof", 32'({last_sof, last_rd}), 32'h122);
        push_byte(8'h33, 3, 2);
        rst = 1'b1; step(); step();
        rst = 1'b0; cs_n = 1'b1;
        step();
        chk("post_reset_count", 32'(count), 32'd0);
        chk("post_reset_empty", 32'(empty), 32'h1);
        push_byte(8'h44, 3, 2);
        cs_n = 1'b0; step();
        push_byte(8'h55, 3, 2);
        pop_n(1);
        chk("post_reset_untagged", 32'({last_sof, last_rd}), 32'h044);
        pop_n(1);
        chk("post_reset_refall", 32'({last_sof, last_rd}), 32'h155);

        // Randomised traffic: fill-biased then drain-biased
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) byte_write = ~byte_write;
            miso_byte = 8'($urandom);
            if ($urandom_range(0, 19) == 0) cs_n = ~cs_n;
            err_clr   = ($urandom_range(0, 29) == 0);
            rd_en     = (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            step();
        end
        rst = 1'b0; byte_write = 1'b0; err_clr = 1'b0;
        pop_n(20);
        repeat (3) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_rx_byte_fifo.md
Name: spi_rx_byte_fifo

Overview:
Receive-side byte buffer placed directly downstream of the SPI master.
- Captures each parallelised MISO byte when the master's byte-complete flag rises.
- Tags the first byte after each chip-select assertion as start-of-frame.
- Holds bytes until the consumer reads them.
- Decouples slow SPI byte production (one byte per ~8 SPI clocks) from the system-clock-rate consumer.

Parameters:
DATA_W, 8, payload byte width
DEPTH, 16, number of entries; must be a power of two
ADDR_W, 4, log2(DEPTH); pointer width

Ports:
clk  in  1  system clock (same clock as the SPI master)
rst  in  1  synchronous active-high reset
byte_write  in  1  master byte-complete level; held high for many clk cycles; only its rising edge matters
miso_byte  in  DATA_W  parallel MISO byte from master; stable when byte_write rises
cs_n  in  1  master chip-select output, active low; frame boundary source
rd_en  in  1  consumer pop request
rd_data  out  DATA_W  popped byte, registered
rd_sof  out  1  popped byte was the first byte of a CS frame
rd_valid  out  1  one-cycle pulse; rd_data/rd_sof valid
empty  out  1  no entries stored
full  out  1  DEPTH entries stored
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a byte was dropped because the FIFO was full
underflow  out  1  sticky: rd_en was asserted while empty
err_clr  in  1  clears both sticky flags

Behaviour:
- Reset (rst=1 at posedge): pointers=0, count=0, empty=1, full=0, rd_data=0, rd_sof=0, rd_valid=0, overflow=0, underflow=0, bw_q=0, cs_q=1, sof_arm=0. Storage contents are don't-care.
- Write detect: bw_q registers byte_write. wr_req = byte_write & ~bw_q, so exactly one push per high phase of byte_write.
- Pushed data: miso_byte sampled in the same cycle wr_req is true. Stored entry = {sof_arm, miso_byte}, width DATA_W+1.
- Frame tagging: cs_q registers cs_n.
  - On a falling cs_n (cs_q=1, cs_n=0): sof_arm <= 1.
  - On an accepted push: sof_arm <= 0.
  - If both happen in the same cycle: the push uses the old sof_arm, then sof_arm is set to 1.
- Read: rd_en & ~empty pops. rd_data/rd_sof are loaded next posedge and rd_valid pulses high for one cycle. There is no fall-through, so 1-cycle read latency.
- rd_en while empty: no pop, rd_valid=0, rd_data holds its value, underflow <= 1.
- Full handling:
  - Push while full with no same-cycle pop: byte dropped, pointers unchanged, overflow <= 1.
  - Push while full with a same-cycle pop: both proceed, count unchanged.
- Empty handling: push while empty with a same-cycle rd_en: push accepted, pop ignored, underflow set.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither. empty = (count==0), full = (count==DEPTH), both derived combinationally from the count register.
- Pointers: ADDR_W bits, wrap naturally from DEPTH−1 to 0.
- Sticky flags: err_clr clears both. A same-cycle set event wins over err_clr.
- Reset mid-frame: all state is discarded. The first push after reset is tagged sof only if a cs_n fall is seen after reset.

Decomposition:
- Shared package spi_pkg holds: DATA_W, FIFO depth default, entry width (DATA_W+1), SOF bit index.
- One natural sub-module, rise_detect (1-bit registered edge detector). Instantiate it for byte_write; the falling-edge variant, or an inverted input, serves cs_n.
- Storage is an inferred register array in the top module.

Test Plan:
- Reset, then cs_n 1→0 and three byte_write pulses (each high 50 clk) with bytes 0xA1, 0xB2, 0xC3 → count=3; three rd_en pops return A1 (sof=1), B2 (sof=0), C3 (sof=0), each rd_valid one cycle after rd_en.
- Hold byte_write high 200 cycles with miso_byte changing → exactly one push, count=1.
- 17 pushes of 0x00..0x10, no reads → full=1 after the 16th, overflow=1, 0x10 dropped; 16 pops return 0x00..0x0F in order.
- Full FIFO, push and rd_en in the same cycle → count stays 16, overflow stays 0, the last pop returns the new byte.
- rd_en while empty → rd_valid=0, underflow=1; err_clr pulse → underflow=0; err_clr with a same-cycle empty read → underflow stays 1.
- cs_n toggles 0→1→0 between bytes 0x11 and 0x22; rst asserted mid-frame → both bytes tagged sof=1; after reset count=0, empty=1, and the next byte is untagged unless cs_n falls again.
